// File: rtl/cpu_pkg.sv
// Shared constants for the microcoded CPU: opcodes, control-word bit positions
// and instruction-cycle step numbers.
package cpu_pkg;

  localparam int NUM_STEPS = 5;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int B_PC_OUT   = 0;
  localparam int B_PC_INC   = 1;
  localparam int B_PC_LOAD  = 2;
  localparam int B_MAR_IN   = 3;
  localparam int B_RAM_IN   = 4;
  localparam int B_RAM_OUT  = 5;
  localparam int B_IR_IN    = 6;
  localparam int B_IR_OUT   = 7;
  localparam int B_A_IN     = 8;
  localparam int B_A_OUT    = 9;
  localparam int B_B_IN     = 10;
  localparam int B_ALU_OUT  = 11;
  localparam int B_ALU_SUB  = 12;
  localparam int B_FLAGS_IN = 13;
  localparam int B_OUT_IN   = 14;
  localparam int B_HALT     = 15;

endpackage

// File: rtl/cu_decode.sv
// Pure combinational microcode decode: opcode, T-step, flags and halt latch
// to the 16-bit control word.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic        halted,
  output logic [15:0] ctrl
);

  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl[B_HALT] = 1'b1;
    end else begin
      case (step)
        T0: begin
          ctrl[B_PC_OUT] = 1'b1;
          ctrl[B_MAR_IN] = 1'b1;
        end
        T1: begin
          ctrl[B_RAM_OUT] = 1'b1;
          ctrl[B_IR_IN]   = 1'b1;
          ctrl[B_PC_INC]  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl[B_IR_OUT] = 1'b1;
              ctrl[B_MAR_IN] = 1'b1;
            end
            OP_LDI: begin
              ctrl[B_IR_OUT] = 1'b1;
              ctrl[B_A_IN]   = 1'b1;
            end
            OP_JMP: begin
              ctrl[B_IR_OUT]  = 1'b1;
              ctrl[B_PC_LOAD] = 1'b1;
            end
            // Conditional jumps only look at the flags in this one step.
            OP_JC: begin
              ctrl[B_IR_OUT]  = flag_c;
              ctrl[B_PC_LOAD] = flag_c;
            end
            OP_JZ: begin
              ctrl[B_IR_OUT]  = flag_z;
              ctrl[B_PC_LOAD] = flag_z;
            end
            OP_OUT: begin
              ctrl[B_A_OUT]  = 1'b1;
              ctrl[B_OUT_IN] = 1'b1;
            end
            OP_HLT: ctrl[B_HALT] = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ctrl[B_RAM_OUT] = 1'b1;
              ctrl[B_A_IN]    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl[B_RAM_OUT] = 1'b1;
              ctrl[B_B_IN]    = 1'b1;
            end
            OP_STA: begin
              ctrl[B_A_OUT]  = 1'b1;
              ctrl[B_RAM_IN] = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl[B_ALU_OUT]  = 1'b1;
            ctrl[B_A_IN]     = 1'b1;
            ctrl[B_FLAGS_IN] = 1'b1;
            ctrl[B_ALU_SUB]  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// CPU control unit: instruction register, 5-step T-counter and halt latch,
// with the IR operand driven onto the shared bus when requested.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [7:0]  cu_bus_8,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl_16,
  output logic [2:0]  step_3
);

  logic [7:0] ir, ir_nxt;
  logic [2:0] step, step_nxt;
  logic       halted, halted_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= 8'h00;
      step   <= T0;
      halted <= 1'b0;
    end else begin
      ir     <= ir_nxt;
      step   <= step_nxt;
      halted <= halted_nxt;
    end
  end

  // Once halted, the step counter freezes where HLT left it (T2).
  always_comb begin
    ir_nxt     = ir;
    step_nxt   = step;
    halted_nxt = halted;
    if (!halted) begin
      if (ctrl_16[B_IR_IN])
        ir_nxt = cu_bus_8;
      if (ctrl_16[B_HALT])
        halted_nxt = 1'b1;
      else if (step == 3'(NUM_STEPS - 1))
        step_nxt = T0;
      else
        step_nxt = step + 3'd1;
    end
  end

  cu_decode u_decode (
    .opcode (ir[7:4]),
    .step   (step),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .halted (halted),
    .ctrl   (ctrl_16)
  );

  assign cu_bus_8 = ctrl_16[B_IR_OUT] ? {4'b0000, ir[3:0]} : 8'hzz;
  assign step_3   = step;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: step-level reference model checked every cycle,
// plus directed instruction sequences with hand-computed control words.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic [15:0] ctrl_16;
  logic [2:0]  step_3;
  wire  [7:0]  cu_bus_8;

  logic [7:0]  mem_data = 8'h00;
  int          errors = 0;
  int          checks = 0;

  int          m_step;
  logic [7:0]  m_ir;
  logic        m_halt;
  logic [15:0] m_ctrl;
  logic        tb_en;
  logic [7:0]  tb_val;
  logic [7:0]  m_bus;

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cu_bus_8 (cu_bus_8),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .ctrl_16  (ctrl_16),
    .step_3   (step_3)
  );

  always #5 clk = ~clk;

  // Control word expected for an opcode in a given step, from the instruction table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] op, input int st,
                                           input logic fc, input logic fz, input logic hl);
    if (hl) return 16'h8000;
    if (st == 0) return 16'h0009;
    if (st == 1) return 16'h0062;
    case (op)
      4'h1: return (st == 2) ? 16'h0088 : (st == 3) ? 16'h0120 : 16'h0000;
      4'h2: return (st == 2) ? 16'h0088 : (st == 3) ? 16'h0420 : 16'h2900;
      4'h3: return (st == 2) ? 16'h0088 : (st == 3) ? 16'h0420 : 16'h3900;
      4'h4: return (st == 2) ? 16'h0088 : (st == 3) ? 16'h0210 : 16'h0000;
      4'h5: return (st == 2) ? 16'h0180 : 16'h0000;
      4'h6: return (st == 2) ? 16'h0084 : 16'h0000;
      4'h7: return (st == 2 && fc) ? 16'h0084 : 16'h0000;
      4'h8: return (st == 2 && fz) ? 16'h0084 : 16'h0000;
      4'hE: return (st == 2) ? 16'h4200 : 16'h0000;
      4'hF: return (st == 2) ? 16'h8000 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 0;
      m_ir   <= 8'h00;
      m_halt <= 1'b0;
    end else if (!m_halt) begin
      if (m_step == 1) m_ir <= mem_data;
      if (m_step == 2 && m_ir[7:4] == 4'hF) m_halt <= 1'b1;
      else m_step <= (m_step + 1) % 5;
    end
  end

  // Memory answers when the model says RAM is read; otherwise an idle pattern
  // is driven whenever the control unit must stay off the bus.
  always_comb begin
    m_ctrl = exp_ctrl(m_ir[7:4], m_step, flag_c, flag_z, m_halt);
    tb_en  = !m_ctrl[7];
    tb_val = m_ctrl[5] ? mem_data : 8'hA5;
    m_bus  = m_ctrl[7] ? {4'h0, m_ir[3:0]} : tb_val;
  end

  assign cu_bus_8 = tb_en ? tb_val : 8'hzz;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int drivers;
    chk("model_ctrl", ctrl_16, m_ctrl);
    chk("model_step", {13'b0, step_3}, 16'(m_step));
    chk("model_bus", {8'h00, cu_bus_8}, {8'h00, m_bus});
    drivers = int'(ctrl_16[0]) + int'(ctrl_16[5]) + int'(ctrl_16[7]) +
              int'(ctrl_16[9]) + int'(ctrl_16[11]);
    chk("bus_drivers", 16'(drivers > 1), 16'h0000);
  end

  // Called mid-T0; walks one full instruction and returns mid-T0 of the next.
  task automatic exec(input logic [7:0] code, input logic fc, input logic fz,
                      input logic [15:0] e2, input logic [15:0] e3,
                      input logic [15:0] e4, input logic [7:0] b2);
    flag_c   = fc;
    flag_z   = fz;
    mem_data = code;
    chk($sformatf("op%02h_T0", code), ctrl_16, 16'h0009);
    @(negedge clk);
    chk($sformatf("op%02h_T1", code), ctrl_16, 16'h0062);
    @(negedge clk);
    chk($sformatf("op%02h_T2", code), ctrl_16, e2);
    chk($sformatf("op%02h_T2_bus", code), {8'h00, cu_bus_8}, {8'h00, b2});
    @(negedge clk);
    chk($sformatf("op%02h_T3", code), ctrl_16, e3);
    @(negedge clk);
    chk($sformatf("op%02h_T4", code), ctrl_16, e4);
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_ctrl", ctrl_16, 16'h0009);
    chk("reset_step", {13'b0, step_3}, 16'h0000);
    chk("reset_bus", {8'h00, cu_bus_8}, 16'h00A5);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    exec(8'h1F, 1'b0, 1'b0, 16'h0088, 16'h0120, 16'h0000, 8'h0F);
    exec(8'h2F, 1'b1, 1'b1, 16'h0088, 16'h0420, 16'h2900, 8'h0F);
    exec(8'h3F, 1'b0, 1'b0, 16'h0088, 16'h0420, 16'h3900, 8'h0F);
    exec(8'h7C, 1'b1, 1'b0, 16'h0084, 16'h0000, 16'h0000, 8'h0C);
    exec(8'h7C, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 8'hA5);
    exec(8'h83, 1'b0, 1'b1, 16'h0084, 16'h0000, 16'h0000, 8'h03);
    exec(8'h83, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'hA5);
    exec(8'h47, 1'b0, 1'b0, 16'h0088, 16'h0210, 16'h0000, 8'h07);
    exec(8'h59, 1'b0, 1'b0, 16'h0180, 16'h0000, 16'h0000, 8'h09);
    exec(8'h6A, 1'b0, 1'b0, 16'h0084, 16'h0000, 16'h0000, 8'h0A);
    exec(8'hE1, 1'b0, 1'b0, 16'h4200, 16'h0000, 16'h0000, 8'hA5);
    exec(8'hB5, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 8'hA5);
    exec(8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'hA5);

    // Every opcode except HLT, with flags toggling every step.
    for (int op = 0; op < 15; op++) begin
      mem_data = {4'(op), 4'($urandom_range(0, 15))};
      for (int s = 0; s < 5; s++) begin
        flag_c = 1'($urandom_range(0, 1));
        flag_z = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end

    // Abort STA in T3 with an asynchronous reset pulse.
    flag_c = 1'b0;
    flag_z = 1'b0;
    mem_data = 8'h4A;
    repeat (2) @(negedge clk);
    chk("sta_T2", ctrl_16, 16'h0088);
    chk("sta_T2_bus", {8'h00, cu_bus_8}, 16'h000A);
    @(negedge clk);
    chk("sta_T3", ctrl_16, 16'h0210);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", ctrl_16, 16'h0009);
    chk("abort_step", {13'b0, step_3}, 16'h0000);
    @(negedge clk);
    chk("abort_held", ctrl_16, 16'h0009);
    rst_n = 1'b1;
    mem_data = 8'h5B;
    @(negedge clk);
    chk("post_abort_T1", ctrl_16, 16'h0062);
    chk("post_abort_step", {13'b0, step_3}, 16'h0001);
    @(negedge clk);
    chk("post_abort_T2", ctrl_16, 16'h0180);
    chk("post_abort_bus", {8'h00, cu_bus_8}, 16'h000B);
    repeat (3) @(negedge clk);

    // Halt, stay frozen, then recover through reset.
    mem_data = 8'hF0;
    chk("hlt_T0", ctrl_16, 16'h0009);
    @(negedge clk);
    chk("hlt_T1", ctrl_16, 16'h0062);
    @(negedge clk);
    chk("hlt_T2", ctrl_16, 16'h8000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flag_c = ~flag_c;
      chk("halted_ctrl", ctrl_16, 16'h8000);
      chk("halted_step", {13'b0, step_3}, 16'h0002);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("unhalt_ctrl", ctrl_16, 16'h0009);
    chk("unhalt_step", {13'b0, step_3}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exec(8'h2F, 1'b0, 1'b0, 16'h0088, 16'h0420, 16'h2900, 8'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
